// File: rtl/hum_act_ctrl_if.sv
// Bus bundle for hum_act_ctrl: controller inputs (enable, sample strobe, thresholds)
// and the actuator, state and configuration-error outputs.
interface hum_act_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              ctrl_en;
   logic              hum_valid;
   logic [DATA_W-1:0] hum_data;
   logic [DATA_W-1:0] low_th;
   logic [DATA_W-1:0] high_th;
   logic              humidifier_en;
   logic              dehumidifier_en;
   logic [1:0]        state;
   logic              cfg_err;

   // Driver side (environment / system controller).
   modport master (
      output ctrl_en, hum_valid, hum_data, low_th, high_th,
      input  humidifier_en, dehumidifier_en, state, cfg_err
   );

   // Controller side.
   modport slave (
      input  ctrl_en, hum_valid, hum_data, low_th, high_th,
      output humidifier_en, dehumidifier_en, state, cfg_err
   );
endinterface

// File: rtl/hum_act_ctrl.sv
// Hysteresis humidity controller: drives a humidifier or dehumidifier (never both) with a
// forced DEAD period between runs. Define HUM_ACT_CTRL_MIN_RUN_EN to enforce a minimum on-time.
module hum_act_ctrl #(
   parameter int DATA_W         = 8,
   parameter int MIN_RUN_CYCLES = 300_000_000,
   parameter int DEAD_CYCLES    = 100_000_000
) (
   input logic           pclk,
   input logic           presetn,
   hum_act_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_HUMIDIFY   = 2'd1,
      ST_DEHUMIDIFY = 2'd2,
      ST_DEAD       = 2'd3
   } state_e;

`ifdef HUM_ACT_CTRL_MIN_RUN_EN
   localparam int CNT_MAX = (MIN_RUN_CYCLES > DEAD_CYCLES) ? MIN_RUN_CYCLES : DEAD_CYCLES;
`else
   localparam int CNT_MAX = DEAD_CYCLES;
`endif
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
`ifdef HUM_ACT_CTRL_MIN_RUN_EN
   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MIN_RUN_CYCLES - 1);
`endif

   if (DATA_W < 1 || DEAD_CYCLES < 1 || MIN_RUN_CYCLES < 1) begin : g_param_check
      $error("hum_act_ctrl: DATA_W, DEAD_CYCLES and MIN_RUN_CYCLES must all be >= 1");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hum_en_q, hum_en_d;
   logic             dehum_en_q, dehum_en_d;

   logic              cfg_err_w;
   logic [DATA_W:0]   target;
   logic              at_or_above_target;
   logic              at_or_below_target;
   logic              run_ok;
   logic              stop_req;

   // hum_valid is a one-cycle strobe with no back-pressure: every cycle it is high is
   // evaluated against the current state, so back-to-back samples are never dropped.
   assign cfg_err_w = (bus.low_th >= bus.high_th);

   // One extra bit keeps the threshold sum from wrapping before the halving shift.
   assign target = ({1'b0, bus.low_th} + {1'b0, bus.high_th}) >> 1;

   assign at_or_above_target = ({1'b0, bus.hum_data} >= target);
   assign at_or_below_target = ({1'b0, bus.hum_data} <= target);

`ifdef HUM_ACT_CTRL_MIN_RUN_EN
   assign run_ok = (cnt_q >= RUN_LAST);
`else
   assign run_ok = 1'b1;
`endif

   // Losing enable or a bad threshold pair aborts a run immediately, ignoring min-run.
   assign stop_req = !bus.ctrl_en || cfg_err_w;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.hum_valid && bus.ctrl_en && !cfg_err_w) begin
               if (bus.hum_data < bus.low_th) begin
                  state_d = ST_HUMIDIFY;
               end else if (bus.hum_data > bus.high_th) begin
                  state_d = ST_DEHUMIDIFY;
               end
            end
         end
         ST_HUMIDIFY: begin
            if (stop_req) begin
               state_d = ST_DEAD;
            end else if (bus.hum_valid && at_or_above_target && run_ok) begin
               state_d = ST_DEAD;
            end
         end
         ST_DEHUMIDIFY: begin
            if (stop_req) begin
               state_d = ST_DEAD;
            end else if (bus.hum_valid && at_or_below_target && run_ok) begin
               state_d = ST_DEAD;
            end
         end
         ST_DEAD: begin
            if (cnt_q == DEAD_LAST) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The counter restarts on every state change, so it always measures time-in-state.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q != ST_IDLE && cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      hum_en_d   = (state_d == ST_HUMIDIFY);
      dehum_en_d = (state_d == ST_DEHUMIDIFY);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         hum_en_q   <= 1'b0;
         dehum_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hum_en_q   <= hum_en_d;
         dehum_en_q <= dehum_en_d;
      end
   end

   assign bus.humidifier_en   = hum_en_q;
   assign bus.dehumidifier_en = dehum_en_q;
   assign bus.state           = state_q;
   assign bus.cfg_err         = cfg_err_w;

endmodule

// File: tb/tb_hum_act_ctrl.sv
// Self-checking bench for hum_act_ctrl (MIN_RUN_CYCLES=8, DEAD_CYCLES=4, DATA_W=8) using a
// mode/age reference model; expectations follow HUM_ACT_CTRL_MIN_RUN_EN when it is defined.
module tb_hum_act_ctrl;

   localparam int DATA_W  = 8;
   localparam int MIN_RUN = 8;
   localparam int DEAD    = 4;

   localparam int M_IDLE = 0;
   localparam int M_HUM  = 1;
   localparam int M_DEH  = 2;
   localparam int M_DEAD = 3;

   logic pclk    = 1'b0;
   logic presetn = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: which mode the controller is in and how many cycles it has been there.
   int m_mode = M_IDLE;
   int m_age  = 0;

   hum_act_ctrl_if #(.DATA_W(DATA_W)) bus ();

   hum_act_ctrl #(
      .DATA_W        (DATA_W),
      .MIN_RUN_CYCLES(MIN_RUN),
      .DEAD_CYCLES   (DEAD)
   ) dut (
      .pclk   (pclk),
      .presetn(presetn),
      .bus    (bus)
   );

   always #5 pclk = ~pclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

   function automatic bit model_run_ok();
`ifdef HUM_ACT_CTRL_MIN_RUN_EN
      return (m_age >= MIN_RUN - 1);
`else
      return 1'b1;
`endif
   endfunction

   // Advance the model by one clock using the inputs currently on the bus.
   task automatic model_step();
      int lo, hi, d, tgt;
      bit err, en, v;
      lo  = int'(bus.low_th);
      hi  = int'(bus.high_th);
      d   = int'(bus.hum_data);
      tgt = (lo + hi) / 2;
      err = (lo >= hi);
      en  = bus.ctrl_en;
      v   = bus.hum_valid;
      case (m_mode)
         M_IDLE: begin
            if (v && en && !err && d < lo) begin
               m_mode = M_HUM; m_age = 0;
            end else if (v && en && !err && d > hi) begin
               m_mode = M_DEH; m_age = 0;
            end
         end
         M_HUM: begin
            if (!en || err || (v && d >= tgt && model_run_ok())) begin
               m_mode = M_DEAD; m_age = 0;
            end else m_age++;
         end
         M_DEH: begin
            if (!en || err || (v && d <= tgt && model_run_ok())) begin
               m_mode = M_DEAD; m_age = 0;
            end else m_age++;
         end
         default: begin
            if (m_age == DEAD - 1) begin
               m_mode = M_IDLE; m_age = 0;
            end else m_age++;
         end
      endcase
   endtask

   task automatic tick();
      model_step();
      @(posedge pclk);
      #1;
   endtask

   task automatic drive(input bit v, input int d);
      bus.hum_valid = v;
      bus.hum_data  = DATA_W'(d);
      tick();
   endtask

   // Force the controller back to IDLE through DEAD, checking each cycle against the model.
   task automatic settle(input string tag);
      bus.ctrl_en   = 1'b0;
      bus.hum_valid = 1'b0;
      for (int i = 0; i < 20 && m_mode != M_IDLE; i++) begin
         tick();
         n_checks++;
         if (bus.state !== 2'(m_mode)) $display("FAIL %s_settle_state: got %0d expected %0d", tag, bus.state, m_mode);
         else n_pass++;
      end
      n_checks++;
      if (bus.state !== 2'(M_IDLE)) $display("FAIL %s_settle_idle: got %0d expected %0d", tag, bus.state, M_IDLE);
      else n_pass++;
      bus.ctrl_en = 1'b1;
   endtask

   task automatic test_reset();
      bus.ctrl_en   = 1'b1;
      bus.hum_valid = 1'b1;
      bus.hum_data  = DATA_W'(30);
      bus.low_th    = DATA_W'(40);
      bus.high_th   = DATA_W'(60);
      presetn       = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      n_checks++;
      if (bus.state !== 2'(M_IDLE)) $display("FAIL reset_state: got %0d expected 0", bus.state);
      else n_pass++;
      n_checks++;
      if (bus.humidifier_en !== 1'b0) $display("FAIL reset_hum_en: got %b expected 0", bus.humidifier_en);
      else n_pass++;
      n_checks++;
      if (bus.dehumidifier_en !== 1'b0) $display("FAIL reset_dehum_en: got %b expected 0", bus.dehumidifier_en);
      else n_pass++;
      n_checks++;
      if (bus.cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b expected 0", bus.cfg_err);
      else n_pass++;
      bus.hum_valid = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
      m_mode  = M_IDLE;
      m_age   = 0;
      @(posedge pclk);
      #1;
   endtask

   task automatic test_humidify();
      drive(1'b1, 30);
      n_checks++;
      if (bus.state !== 2'(M_HUM)) $display("FAIL hum_enter_state: got %0d expected 1", bus.state);
      else n_pass++;
      n_checks++;
      if (bus.humidifier_en !== 1'b1 || bus.dehumidifier_en !== 1'b0)
         $display("FAIL hum_enter_en: got hum=%b dehum=%b expected hum=1 dehum=0", bus.humidifier_en, bus.dehumidifier_en);
      else n_pass++;
      repeat (7) drive(1'b0, 0);
      n_checks++;
      if (bus.state !== 2'(M_HUM)) $display("FAIL hum_hold_state: got %0d expected 1", bus.state);
      else n_pass++;
      drive(1'b1, 50);
      n_checks++;
      if (bus.state !== 2'(M_DEAD) || bus.humidifier_en !== 1'b0)
         $display("FAIL hum_to_dead: got state=%0d hum=%b expected state=3 hum=0", bus.state, bus.humidifier_en);
      else n_pass++;
      for (int i = 0; i < DEAD - 1; i++) begin
         drive(1'b0, 0);
         n_checks++;
         if (bus.state !== 2'(M_DEAD)) $display("FAIL hum_dead_len: cycle %0d got %0d expected 3", i + 2, bus.state);
         else n_pass++;
      end
      drive(1'b0, 0);
      n_checks++;
      if (bus.state !== 2'(M_IDLE)) $display("FAIL hum_dead_exit: got %0d expected 0", bus.state);
      else n_pass++;
   endtask

   task automatic test_dehum_min_run();
      logic [1:0] exp_state;
      drive(1'b1, 70);
      n_checks++;
      if (bus.state !== 2'(M_DEH) || bus.dehumidifier_en !== 1'b1)
         $display("FAIL deh_enter: got state=%0d dehum=%b expected state=2 dehum=1", bus.state, bus.dehumidifier_en);
      else n_pass++;
      repeat (2) drive(1'b0, 0);
      drive(1'b1, 45);
`ifdef HUM_ACT_CTRL_MIN_RUN_EN
      exp_state = 2'(M_DEH);
`else
      exp_state = 2'(M_DEAD);
`endif
      n_checks++;
      if (bus.state !== exp_state) $display("FAIL deh_min_run: got %0d expected %0d", bus.state, exp_state);
      else n_pass++;
      settle("deh");
   endtask

   task automatic test_ctrl_en_drop();
      drive(1'b1, 30);
      drive(1'b0, 0);
      n_checks++;
      if (bus.state !== 2'(M_HUM)) $display("FAIL en_drop_pre: got %0d expected 1", bus.state);
      else n_pass++;
      bus.ctrl_en = 1'b0;
      drive(1'b0, 0);
      n_checks++;
      if (bus.state !== 2'(M_DEAD) || bus.humidifier_en !== 1'b0 || bus.dehumidifier_en !== 1'b0)
         $display("FAIL en_drop_dead: got state=%0d hum=%b dehum=%b expected 3/0/0",
                  bus.state, bus.humidifier_en, bus.dehumidifier_en);
      else n_pass++;
      bus.ctrl_en = 1'b1;
      for (int i = 0; i < DEAD - 1; i++) begin
         drive(1'b1, 10);
         n_checks++;
         if (bus.state !== 2'(M_DEAD)) $display("FAIL en_drop_dead_len: cycle %0d got %0d expected 3", i + 2, bus.state);
         else n_pass++;
      end
      drive(1'b0, 0);
      n_checks++;
      if (bus.state !== 2'(M_IDLE)) $display("FAIL en_drop_exit: got %0d expected 0", bus.state);
      else n_pass++;
   endtask

   task automatic test_cfg_err();
      bus.low_th  = DATA_W'(60);
      bus.high_th = DATA_W'(40);
      #1;
      n_checks++;
      if (bus.cfg_err !== 1'b1) $display("FAIL cfg_err_set: got %b expected 1", bus.cfg_err);
      else n_pass++;
      drive(1'b1, 10);
      n_checks++;
      if (bus.state !== 2'(M_IDLE) || bus.humidifier_en !== 1'b0)
         $display("FAIL cfg_err_no_act: got state=%0d hum=%b expected 0/0", bus.state, bus.humidifier_en);
      else n_pass++;
      bus.low_th  = DATA_W'(40);
      bus.high_th = DATA_W'(60);
      #1;
      n_checks++;
      if (bus.cfg_err !== 1'b0) $display("FAIL cfg_err_clear: got %b expected 0", bus.cfg_err);
      else n_pass++;
      drive(1'b1, 30);
      bus.low_th  = DATA_W'(60);
      bus.high_th = DATA_W'(40);
      drive(1'b0, 0);
      n_checks++;
      if (bus.state !== 2'(M_DEAD)) $display("FAIL cfg_err_abort: got %0d expected 3", bus.state);
      else n_pass++;
      bus.low_th  = DATA_W'(40);
      bus.high_th = DATA_W'(60);
      settle("cfg");
   endtask

   task automatic test_back_to_back();
      int seq_d[4] = '{50, 55, 20, 50};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, seq_d[i]);
         n_checks++;
         if (bus.state !== 2'(m_mode)) $display("FAIL b2b_step%0d: got %0d expected %0d", i, bus.state, m_mode);
         else n_pass++;
      end
      n_checks++;
      if (bus.state === 2'(M_IDLE)) $display("FAIL b2b_activated: got %0d expected non-idle", bus.state);
      else n_pass++;
      settle("b2b");
   endtask

   task automatic test_reset_mid_dead();
      drive(1'b1, 70);
      bus.ctrl_en = 1'b0;
      drive(1'b0, 0);
      drive(1'b0, 0);
      n_checks++;
      if (bus.state !== 2'(M_DEAD)) $display("FAIL rst_dead_pre: got %0d expected 3", bus.state);
      else n_pass++;
      presetn = 1'b0;
      #2;
      n_checks++;
      if (bus.state !== 2'(M_IDLE) || bus.humidifier_en !== 1'b0 || bus.dehumidifier_en !== 1'b0)
         $display("FAIL rst_dead_async: got state=%0d hum=%b dehum=%b expected 0/0/0",
                  bus.state, bus.humidifier_en, bus.dehumidifier_en);
      else n_pass++;
      m_mode = M_IDLE;
      m_age  = 0;
      #2;
      presetn     = 1'b1;
      bus.ctrl_en = 1'b1;
      drive(1'b1, 70);
      n_checks++;
      if (bus.state !== 2'(M_DEH) || bus.dehumidifier_en !== 1'b1)
         $display("FAIL rst_first_sample: got state=%0d dehum=%b expected 2/1", bus.state, bus.dehumidifier_en);
      else n_pass++;
      settle("rst");
   endtask

   task automatic test_random();
      logic [1:0] prev_state;
      bit         exp_err;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            bus.low_th  = DATA_W'($urandom_range(20, 60));
            bus.high_th = DATA_W'($urandom_range(40, 90));
         end
         bus.ctrl_en   = ($urandom_range(0, 31) != 0);
         bus.hum_valid = ($urandom_range(0, 1) == 1);
         bus.hum_data  = DATA_W'($urandom_range(0, 120));
         prev_state    = bus.state;
         exp_err       = (int'(bus.low_th) >= int'(bus.high_th));
         tick();
         n_checks++;
         if (bus.state !== 2'(m_mode)) $display("FAIL rnd_state: cycle %0d got %0d expected %0d", i, bus.state, m_mode);
         else n_pass++;
         n_checks++;
         if (bus.humidifier_en !== (m_mode == M_HUM) || bus.dehumidifier_en !== (m_mode == M_DEH))
            $display("FAIL rnd_enables: cycle %0d got hum=%b dehum=%b expected mode %0d",
                     i, bus.humidifier_en, bus.dehumidifier_en, m_mode);
         else n_pass++;
         n_checks++;
         if (bus.cfg_err !== exp_err) $display("FAIL rnd_cfg_err: cycle %0d got %b expected %b", i, bus.cfg_err, exp_err);
         else n_pass++;
         n_checks++;
         if (bus.humidifier_en === 1'b1 && bus.dehumidifier_en === 1'b1)
            $display("FAIL rnd_exclusive: cycle %0d got both enables 1 expected at most one", i);
         else n_pass++;
         n_checks++;
         if ((prev_state == 2'(M_HUM) && bus.state == 2'(M_DEH)) ||
             (prev_state == 2'(M_DEH) && bus.state == 2'(M_HUM)))
            $display("FAIL rnd_direct_flip: cycle %0d got %0d->%0d expected via DEAD", i, prev_state, bus.state);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_humidify();
      test_dehum_min_run();
      test_ctrl_en_drop();
      test_cfg_err();
      test_back_to_back();
      test_reset_mid_dead();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
